uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_receiver_if.sv | 35 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_receiver.sv | 154 +++++++++++++++
 tb/tb_uart_receiver.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width and baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // System clocks per serial bit (integer divide).
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bus: serial pin plus byte holding register handshake.
interface uart_receiver_if;
  import uart_pkg::*;

  logic              rx_serial;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              frame_error;
  logic              overrun;
  logic              busy;

  // Receiver side
  modport master (
    input  rx_serial,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output frame_error,
    output overrun,
    output busy
  );

  // Consumer / line side
  modport slave (
    output rx_serial,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with configurable reset value.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronization of the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 LSB-first UART receiver with holding register and valid/ack handshake.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 20_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.master bus
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  logic              rx_sync;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              fe_q, fe_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;
  logic              at_half;
  logic              at_full;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx_serial),
    .q_o   (rx_sync)
  );

  assign at_half = (cnt_q == CNT_W'(HALF - 1));
  assign at_full = (cnt_q == CNT_W'(CPB - 1));

  // Next-state: frame sequencing, sampling and delivery into the holding register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ovr_d   = ovr_q;

    if (bus.rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (at_half) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (at_full) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (at_full) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = ST_IDLE;
            // A consumer ack in the same cycle frees the register for the new byte.
            if (!valid_q || bus.rx_ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rx_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_error = fe_q;
  assign bus.overrun     = ovr_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 10 clocks per bit: vector table, corner sequences, random frames.
module tb_uart_receiver;

  localparam int unsigned BIT_CLKS = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   fe_cnt = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;
  int   start_cyc = 0;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe valid rising edges and frame_error cycles.
  always @(negedge clk) begin
    if (bus.rx_valid && !prev_v) rise_cyc <= cyc;
    prev_v <= bus.rx_valid;
    if (bus.frame_error) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         ack_start;
    bit         chk_lat;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_fe_inc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    bus.rx_serial = v;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; optional ack pulse in the first start-bit cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_start);
    start_cyc = cyc;
    if (ack_start) bus.rx_ack = 1'b1;
    bus.rx_serial = 1'b0;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    line(1'b0, BIT_CLKS - 1);
    for (int i = 0; i < 8; i++) line(b[i], BIT_CLKS);
    line(stop_ok, BIT_CLKS);
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  logic [7:0] mdata;
  logic       mvalid;
  logic       movr;
  int         mfe;
  int         fe_base;
  int         lat;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 0};
    vecs[3] = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 0};
    vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 0};

    bus.rx_serial = 1'b1;
    bus.rx_ack    = 1'b0;
    @(negedge clk);
    check("reset_data",  32'(bus.rx_data), 32'h00);
    check("reset_valid", 32'(bus.rx_valid), 0);
    check("reset_fe",    32'(bus.frame_error), 0);
    check("reset_ovr",   32'(bus.overrun), 0);
    check("reset_busy",  32'(bus.busy), 0);
    reset = 1'b0;
    line(1'b1, 5);

    // Short low glitch must be rejected at the start-bit centre.
    fe_base = fe_cnt;
    line(1'b0, 3);
    line(1'b1, 3);
    check("glitch_busy_mid", 32'(bus.busy), 1);
    line(1'b1, 9);
    check("glitch_busy_end", 32'(bus.busy), 0);
    check("glitch_valid",    32'(bus.rx_valid), 0);
    check("glitch_fe",       32'(fe_cnt - fe_base), 0);

    // Vector table: frames sent back-to-back unless a break is involved.
    for (int i = 0; i < 7; i++) begin
      fe_base = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].ack_start);
      if (!vecs[i].stop_ok) begin
        line(1'b0, 50);
        check($sformatf("v%0d_busy_break", i), 32'(bus.busy), 1);
        line(1'b1, 4);
        check($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 0);
      end
      if (vecs[i].chk_lat) begin
        lat = rise_cyc - start_cyc;
        checks++;
        if (lat < 97 || lat > 99) begin
          errors++;
          $display("FAIL v%0d_latency: got %0d expected 98+-1", i, lat);
        end
      end
      check($sformatf("v%0d_valid", i), 32'(bus.rx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_data", i),  32'(bus.rx_data),  32'(vecs[i].exp_data));
      check($sformatf("v%0d_ovr", i),   32'(bus.overrun),  32'(vecs[i].exp_ovr));
      check($sformatf("v%0d_fe", i),    32'(fe_cnt - fe_base), 32'(vecs[i].exp_fe_inc));
    end

    // Ack drops valid on the following cycle.
    ack_pulse();
    check("ack_valid_fall", 32'(bus.rx_valid), 0);
    line(1'b1, 3);

    // Ack coinciding with the stop sample replaces the byte without overrun.
    send_frame(8'h66, 1'b1, 1'b0);
    check("pre_coinc_data", 32'(bus.rx_data), 32'h66);
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        repeat (97) @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
      end
    join
    check("coinc_valid", 32'(bus.rx_valid), 1);
    check("coinc_data",  32'(bus.rx_data), 32'h77);
    check("coinc_ovr",   32'(bus.overrun), 0);
    line(1'b1, 3);

    // Reset during bit 4 aborts the frame; the next frame is clean.
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) line(1'(i & 1), BIT_CLKS);
    bus.rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    line(1'b1, 2);
    check("rst_mid_data",  32'(bus.rx_data), 32'h00);
    check("rst_mid_valid", 32'(bus.rx_valid), 0);
    check("rst_mid_fe",    32'(bus.frame_error), 0);
    check("rst_mid_ovr",   32'(bus.overrun), 0);
    check("rst_mid_busy",  32'(bus.busy), 0);
    reset = 1'b0;
    line(1'b1, 5);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("post_rst_valid", 32'(bus.rx_valid), 1);
    check("post_rst_data",  32'(bus.rx_data), 32'h5A);

    // Random frames against a handshake reference model.
    mdata  = 8'h5A;
    mvalid = 1'b1;
    movr   = 1'b0;
    mfe    = 0;
    fe_base = fe_cnt;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      bit ok;
      bit ak;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      ak = 1'($urandom_range(0, 1));
      if (ak) begin
        mvalid = 1'b0;
        movr   = 1'b0;
      end
      send_frame(b, ok, ak);
      if (ok) begin
        if (!mvalid) begin
          mdata  = b;
          mvalid = 1'b1;
        end else begin
          movr = 1'b1;
        end
      end else begin
        mfe++;
        line(1'b0, $urandom_range(0, 20));
      end
      line(1'b1, $urandom_range(3, 6));
      check($sformatf("r%0d_valid", k), 32'(bus.rx_valid), 32'(mvalid));
      check($sformatf("r%0d_data", k),  32'(bus.rx_data),  32'(mdata));
      check($sformatf("r%0d_ovr", k),   32'(bus.overrun),  32'(movr));
      check($sformatf("r%0d_fe", k),    32'(fe_cnt - fe_base), 32'(mfe));
      check($sformatf("r%0d_busy", k),  32'(bus.busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
